w0rm_core_branch_ras: RTL

Parametrised branch resolution unit for the W0RM core, the successor of the single-purpose branch stage. It evaluates conditional and unconditional branches against the ALU flags and computes absolute or relative targets. It adds a configurable-depth return address stack (RAS), so returns are redirected without waiting on the link register. It sits between the decode/ALU stages and the fetch unit, and its flush and next-PC outputs feed the fetch unit.

---
 rtl/w0rm_core_branch_ras.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/w0rm_core_branch_ras.sv
// Branch resolution unit for the W0RM core: evaluates branch conditions, forms targets and
// predicts returns from a circular return address stack, behind a single output register.
module w0rm_core_branch_ras #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned USER_WIDTH  = 1,
  parameter int unsigned RAS_DEPTH   = 4,
  parameter int unsigned LINK_OFFSET = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mem_ready,
  output logic                        branch_ready,
  input  logic                        data_valid,
  input  logic                        is_branch,
  input  logic                        is_cond_branch,
  input  logic                        is_call,
  input  logic                        is_return,
  input  logic [2:0]                  cond_branch_code,
  input  logic                        alu_flag_zero,
  input  logic                        alu_flag_negative,
  input  logic                        alu_flag_carry,
  input  logic                        alu_flag_overflow,
  input  logic                        branch_rel_abs,
  input  logic [DATA_WIDTH-1:0]       branch_base_addr,
  input  logic [DATA_WIDTH-1:0]       rn,
  input  logic [DATA_WIDTH-1:0]       lit,
  input  logic                        ras_clear,
  input  logic [USER_WIDTH-1:0]       user_data_in,
  output logic                        branch_valid,
  output logic                        flush_pipeline,
  output logic                        next_pc_valid,
  output logic [ADDR_WIDTH-1:0]       next_pc,
  output logic [ADDR_WIDTH-1:0]       next_link_reg,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic [USER_WIDTH-1:0]       user_data_out
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SumW = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;

  logic                  valid_q, flush_q, npv_q;
  logic [ADDR_WIDTH-1:0] pc_q, link_q;
  logic [USER_WIDTH-1:0] user_q;

  logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [PtrW-1:0]       ptr_q, ptr_d, top_idx;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic                  accept, cond, taken, ras_hit, push, pop;
  logic [SumW-1:0]       base_ext, rn_ext, lit_ext;
  logic [ADDR_WIDTH-1:0] computed, link_addr, ras_top, target;

  assign branch_ready = !valid_q || mem_ready;
  assign accept       = data_valid && branch_ready;

  always_comb begin
    cond = 1'b0;
    unique case (cond_branch_code)
      3'd0: cond = alu_flag_zero;
      3'd1: cond = !alu_flag_zero;
      3'd2: cond = alu_flag_carry;
      3'd3: cond = !alu_flag_carry;
      3'd4: cond = alu_flag_negative;
      3'd5: cond = !alu_flag_negative;
      3'd6: cond = alu_flag_overflow;
      3'd7: cond = !alu_flag_overflow;
      default: cond = 1'b0;
    endcase
  end

  assign taken = is_branch && (!is_cond_branch || cond);

  assign base_ext  = SumW'(branch_base_addr);
  assign rn_ext    = SumW'(rn);
  assign lit_ext   = SumW'(lit);
  assign computed  = ADDR_WIDTH'(branch_rel_abs ? (base_ext + lit_ext) : (rn_ext + lit_ext));
  assign link_addr = ADDR_WIDTH'(base_ext + SumW'(LINK_OFFSET));

  // ptr_q is the next free slot; the top lives one below it and wraps with the pointer.
  assign top_idx = ptr_q - PtrW'(1);
  assign ras_top = ras_q[top_idx];
  assign ras_hit = taken && is_return && (cnt_q != '0);
  assign target  = ras_hit ? ras_top : computed;
  assign push    = accept && taken && is_call;
  assign pop     = accept && ras_hit;

  always_comb begin
    ras_d = ras_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (ras_clear) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (push && pop) begin
      ras_d[top_idx] = link_addr;
    end else if (push) begin
      ras_d[ptr_q] = link_addr;
      ptr_d        = ptr_q + PtrW'(1);
      if (cnt_q != CntW'(RAS_DEPTH)) cnt_d = cnt_q + CntW'(1);
    end else if (pop) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ras_q <= ras_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      npv_q   <= 1'b0;
      pc_q    <= '0;
      link_q  <= '0;
      user_q  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      flush_q <= taken;
      npv_q   <= taken;
      pc_q    <= is_branch ? target : '0;
      link_q  <= link_addr;
      user_q  <= user_data_in;
    end else if (mem_ready) begin
      // Handshake with no new beat: strobes drop, data fields keep their last value.
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      npv_q   <= 1'b0;
    end
  end

  assign branch_valid   = valid_q;
  assign flush_pipeline = flush_q;
  assign next_pc_valid  = npv_q;
  assign next_pc        = pc_q;
  assign next_link_reg  = link_q;
  assign user_data_out  = user_q;
  assign ras_count      = cnt_q;

endmodule
